// File: rtl/gen_sel_sched_if.sv
// rtl/gen_sel_sched_if.sv - request/data/grant/result bundle for gen_sel_sched
interface gen_sel_sched_if;
  logic       req_a;
  logic       req_b;
  logic [3:0] a;
  logic [3:0] b;
  logic       gnt_a;
  logic       gnt_b;
  logic       sel;
  logic [3:0] y;
  logic [3:0] z;
  logic       out_valid;

  // requester side: drives requests and data, observes grants and results
  modport master (
    output req_a, req_b, a, b,
    input  gnt_a, gnt_b, sel, y, z, out_valid
  );

  // scheduler side
  modport slave (
    input  req_a, req_b, a, b,
    output gnt_a, gnt_b, sel, y, z, out_valid
  );
endinterface

// File: rtl/gen_sel_sched.sv
// rtl/gen_sel_sched.sv - two-requester round-robin mux scheduler with hold counter; GEN_SEL_SCHED_CNT_EN adds cnt_a/cnt_b occupancy counters
module gen_sel_sched #(
  parameter int HOLD = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  gen_sel_sched_if.slave  bus
`ifdef GEN_SEL_SCHED_CNT_EN
  ,
  output logic [7:0]      cnt_a,
  output logic [7:0]      cnt_b
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  // value loaded on every grant entry so a grant spans HOLD cycles
  localparam logic [3:0] HOLD_LOAD = 4'(HOLD - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] hold_cnt;
  logic [3:0] hold_nxt;
  logic       last_b;       // 1: B was served last, so A wins the next tie
  logic       last_b_nxt;

  logic       gnt_a_q;
  logic       gnt_b_q;
  logic       sel_q;
  logic       out_valid_q;
  logic [3:0] y_q;
  logic [3:0] z_q;

  // next-state selection: round-robin from IDLE, hold/early-release inside a grant
  always_comb begin
    state_nxt  = state;
    hold_nxt   = hold_cnt;
    last_b_nxt = last_b;
    case (state)
      IDLE: begin
        if (bus.req_a && (!bus.req_b || last_b)) begin
          state_nxt = OWN_A;
          hold_nxt  = HOLD_LOAD;
        end else if (bus.req_b) begin
          state_nxt = OWN_B;
          hold_nxt  = HOLD_LOAD;
        end
      end
      OWN_A: begin
        if (!bus.req_a || hold_cnt == 4'd0) begin
          last_b_nxt = 1'b0;
          if (bus.req_b) begin
            state_nxt = OWN_B;
            hold_nxt  = HOLD_LOAD;
          end else if (bus.req_a) begin
            state_nxt = OWN_A;
            hold_nxt  = HOLD_LOAD;
          end else begin
            state_nxt = IDLE;
            hold_nxt  = 4'd0;
          end
        end else begin
          hold_nxt = hold_cnt - 4'd1;
        end
      end
      OWN_B: begin
        if (!bus.req_b || hold_cnt == 4'd0) begin
          last_b_nxt = 1'b1;
          if (bus.req_a) begin
            state_nxt = OWN_A;
            hold_nxt  = HOLD_LOAD;
          end else if (bus.req_b) begin
            state_nxt = OWN_B;
            hold_nxt  = HOLD_LOAD;
          end else begin
            state_nxt = IDLE;
            hold_nxt  = 4'd0;
          end
        end else begin
          hold_nxt = hold_cnt - 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        hold_nxt  = 4'd0;
      end
    endcase
  end

  // state, registered grants, and steering results captured during granted cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      hold_cnt    <= 4'd0;
      last_b      <= 1'b1;
      gnt_a_q     <= 1'b0;
      gnt_b_q     <= 1'b0;
      sel_q       <= 1'b0;
      out_valid_q <= 1'b0;
      y_q         <= 4'd0;
      z_q         <= 4'd0;
    end else begin
      state       <= state_nxt;
      hold_cnt    <= hold_nxt;
      last_b      <= last_b_nxt;
      gnt_a_q     <= (state_nxt == OWN_A);
      gnt_b_q     <= (state_nxt == OWN_B);
      sel_q       <= (state_nxt == OWN_A);
      out_valid_q <= (state != IDLE);
      if (state != IDLE) begin
        y_q <= sel_q ? bus.a : bus.b;
        z_q <= sel_q ? bus.b : bus.a;
      end
    end
  end

  assign bus.gnt_a     = gnt_a_q;
  assign bus.gnt_b     = gnt_b_q;
  assign bus.sel       = sel_q;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.z         = z_q;

`ifdef GEN_SEL_SCHED_CNT_EN
  // free-running occupancy counters, wrap at 255
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a <= 8'd0;
      cnt_b <= 8'd0;
    end else begin
      if (state == OWN_A) cnt_a <= cnt_a + 8'd1;
      if (state == OWN_B) cnt_b <= cnt_b + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gen_sel_sched.sv
// tb/tb_gen_sel_sched.sv - directed table-driven bench for gen_sel_sched
module tb_gen_sel_sched;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  gen_sel_sched_if bus1 ();
  gen_sel_sched_if bus2 ();
  gen_sel_sched_if bus4 ();

`ifdef GEN_SEL_SCHED_CNT_EN
  logic [7:0] cnt_a1, cnt_b1, cnt_a2, cnt_b2, cnt_a4, cnt_b4;
`endif

  gen_sel_sched #(.HOLD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
`ifdef GEN_SEL_SCHED_CNT_EN
    , .cnt_a(cnt_a1), .cnt_b(cnt_b1)
`endif
  );

  gen_sel_sched #(.HOLD(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
`ifdef GEN_SEL_SCHED_CNT_EN
    , .cnt_a(cnt_a2), .cnt_b(cnt_b2)
`endif
  );

  gen_sel_sched #(.HOLD(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4)
`ifdef GEN_SEL_SCHED_CNT_EN
    , .cnt_a(cnt_a4), .cnt_b(cnt_b4)
`endif
  );

  // expected = {gnt_a, gnt_b, sel, out_valid, y, z}
  typedef struct {
    logic       ra;
    logic       rb;
    logic [3:0] a;
    logic [3:0] b;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs [16];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_all();
    bus1.req_a = 1'b0; bus1.req_b = 1'b0; bus1.a = 4'h0; bus1.b = 4'h0;
    bus2.req_a = 1'b0; bus2.req_b = 1'b0; bus2.a = 4'h0; bus2.b = 4'h0;
    bus4.req_a = 1'b0; bus4.req_b = 1'b0; bus4.a = 4'h0; bus4.b = 4'h0;
  endtask

  task automatic do_reset();
    idle_all();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [11:0] obs2();
    return {bus2.gnt_a, bus2.gnt_b, bus2.sel, bus2.out_valid, bus2.y, bus2.z};
  endfunction

  initial begin
    logic [7:0] pat_a;

    vecs[0]  = '{1'b1, 1'b0, 4'hA, 4'h5, 12'hA00};
    vecs[1]  = '{1'b1, 1'b0, 4'hA, 4'h5, 12'hBA5};
    vecs[2]  = '{1'b0, 1'b0, 4'hA, 4'h5, 12'h1A5};
    vecs[3]  = '{1'b0, 1'b0, 4'hA, 4'h5, 12'h0A5};
    vecs[4]  = '{1'b0, 1'b1, 4'h3, 4'hC, 12'h4A5};
    vecs[5]  = '{1'b0, 1'b1, 4'h3, 4'hC, 12'h5C3};
    vecs[6]  = '{1'b0, 1'b0, 4'h3, 4'hC, 12'h1C3};
    vecs[7]  = '{1'b0, 1'b0, 4'h3, 4'hC, 12'h0C3};
    vecs[8]  = '{1'b1, 1'b1, 4'h1, 4'h2, 12'hAC3};
    vecs[9]  = '{1'b1, 1'b1, 4'h1, 4'h2, 12'hB12};
    vecs[10] = '{1'b1, 1'b1, 4'h6, 4'h9, 12'h569};
    vecs[11] = '{1'b1, 1'b1, 4'h6, 4'h9, 12'h596};
    vecs[12] = '{1'b0, 1'b1, 4'h6, 4'h9, 12'h596};
    vecs[13] = '{1'b0, 1'b1, 4'h6, 4'h9, 12'h596};
    vecs[14] = '{1'b0, 1'b0, 4'h6, 4'h9, 12'h196};
    vecs[15] = '{1'b0, 1'b0, 4'h6, 4'h9, 12'h096};

    // reset asserted before any clock edge
    idle_all();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_dut1", 16'({bus1.gnt_a, bus1.gnt_b, bus1.sel, bus1.out_valid, bus1.y, bus1.z}), 16'h0);
    chk("reset_dut2", 16'(obs2()), 16'h0);
    chk("reset_dut4", 16'({bus4.gnt_a, bus4.gnt_b, bus4.sel, bus4.out_valid, bus4.y, bus4.z}), 16'h0);
    @(negedge clk);

    // table: single requests, early release, ties, expiry re-entry (HOLD=2)
    do_reset();
    for (int i = 0; i < 16; i++) begin
      bus2.req_a = vecs[i].ra;
      bus2.req_b = vecs[i].rb;
      bus2.a     = vecs[i].a;
      bus2.b     = vecs[i].b;
      tick();
      chk($sformatf("vec%0d", i), 16'(obs2()), 16'(vecs[i].exp));
    end

    // both requests held from reset, HOLD=2: A,A,B,B,A,A,B,B
    do_reset();
    pat_a = 8'b00110011;
    bus2.req_a = 1'b1;
    bus2.req_b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("rr_hold2_%0d", i), 16'({bus2.gnt_a, bus2.gnt_b}), 16'({pat_a[i], ~pat_a[i]}));
    end

    // HOLD=1 alternates every cycle
    do_reset();
    bus1.req_a = 1'b1;
    bus1.req_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("rr_hold1_%0d", i), 16'({bus1.gnt_a, bus1.gnt_b}), (i % 2 == 0) ? 16'h2 : 16'h1);
    end

    // HOLD=4 early release into B, then B holds four cycles before A returns
    do_reset();
    bus4.req_a = 1'b1;
    bus4.req_b = 1'b1;
    tick();
    chk("early_own_a", 16'({bus4.gnt_a, bus4.gnt_b}), 16'h2);
    bus4.req_a = 1'b0;
    tick();
    chk("early_to_b", 16'({bus4.gnt_a, bus4.gnt_b}), 16'h1);
    bus4.req_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("hold4_b_%0d", i), 16'({bus4.gnt_a, bus4.gnt_b}), 16'h1);
    end
    tick();
    chk("hold4_back_a", 16'({bus4.gnt_a, bus4.gnt_b}), 16'h2);

    // mid-grant asynchronous reset; last points at A beforehand so the tie proves it was reset
    do_reset();
    bus2.req_a = 1'b1; bus2.a = 4'h7; bus2.b = 4'h8;
    tick();
    bus2.req_a = 1'b0;
    tick();
    bus2.req_a = 1'b1;
    tick();
    tick();
    chk("pre_reset_grant", 16'(obs2()), 16'hB78);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_clear", 16'(obs2()), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus2.req_b = 1'b1;
    #1;
    chk("no_grant_at_release", 16'({bus2.gnt_a, bus2.gnt_b}), 16'h0);
    @(negedge clk);
    chk("tie_after_reset_a", 16'({bus2.gnt_a, bus2.gnt_b}), 16'h2);

`ifdef GEN_SEL_SCHED_CNT_EN
    // req_a alone for 300 edges: OWN_A from edge 1 onwards, count lags one cycle
    do_reset();
    bus2.req_a = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      tick();
      if (n == 256 || n == 257 || n == 300)
        chk($sformatf("cnt_a_at_%0d", n), 16'(cnt_a2), 16'(8'((n - 1) % 256)));
    end
    chk("cnt_b_idle", 16'(cnt_b2), 16'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gen_sel_sched.md
GEN_SEL_SCHED -- requirements
Module: gen_sel_sched

Interface
REQ-001 Parameter HOLD, default 2: cycles a grant is held while its request stays high; legal range 1..15.
REQ-002 clk  input  1  rising-edge clock; all state is on this edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req_a  input  1  requester A wants the steering mux.
REQ-005 req_b  input  1  requester B wants the steering mux.
REQ-006 a  input  4  requester A data.
REQ-007 b  input  4  requester B data.
REQ-008 gnt_a  output  1  A owns the mux this cycle (registered).
REQ-009 gnt_b  output  1  B owns the mux this cycle (registered).
REQ-010 sel  output  1  mux select: 1 while A is granted, else 0 (registered).
REQ-011 y  output  4  registered steering result: y = sel ? a : b, sampled in the granted cycle.
REQ-012 z  output  4  registered complement: z = sel ? b : a, sampled in the granted cycle.
REQ-013 out_valid  output  1  y and z hold a result captured in the previous granted cycle.

Function
REQ-014 The FSM SHALL have three states: IDLE, OWN_A and OWN_B.
- gnt_a = (state == OWN_A); gnt_b = (state == OWN_B).
- gnt_a and gnt_b are never both 1.
REQ-015 From IDLE, the FSM SHALL move as follows:
- only req_a high -> OWN_A.
- only req_b high -> OWN_B.
- both high -> the requester not served last (round-robin pointer `last`).
- neither high -> stay in IDLE.
REQ-016 On entering OWN_x, a 4-bit hold counter SHALL load HOLD-1, then decrement each cycle spent in OWN_x.
REQ-017 In OWN_x, if req_x is low, the grant SHALL end on the next edge (early release); `last` is set to x.
REQ-018 In OWN_x with counter == 0 (grant expiry):
- the other requester high -> switch directly to OWN_other, with no IDLE bubble.
- else req_x high -> re-enter OWN_x with the counter reloaded.
- else -> IDLE.
- `last` is set to x.
REQ-019 When an early release in OWN_x coincides with the other request being high, the FSM SHALL go directly to OWN_other.
REQ-020 Each cycle the FSM is in OWN_A or OWN_B, the outputs SHALL update on the next edge:
- y <= sel ? a : b.
- z <= sel ? b : a.
- out_valid <= 1.
REQ-021 In any other cycle, out_valid SHALL be 0 on the next edge, and y and z keep their last values.
REQ-022 Latency: req high in IDLE -> grant one cycle later -> out_valid two cycles after the request.
REQ-023 With HOLD=1, each grant SHALL last exactly one cycle; with both requests held high, grants alternate A, B, A, B.
REQ-024 With both requests held high continuously, each requester SHALL receive HOLD consecutive grant cycles per turn; no starvation.
REQ-025 Request changes SHALL affect the grant only at a clock edge; the grant is never a combinational function of req.

Reset
REQ-026 While rst_n is low, the block SHALL hold the following values, independent of clk:
- state = IDLE.
- gnt_a = gnt_b = sel = 0.
- y = z = 0.
- out_valid = 0.
- hold counter = 0.
- `last` = B, so A wins the first tie.
REQ-027 Reset asserted mid-grant SHALL abort the grant immediately; after deassertion the first tie goes to A.
REQ-028 Reset deassertion SHALL take effect at the first rising edge with rst_n high; no grant is issued in that same cycle.

Configuration
REQ-029 Macro GEN_SEL_SCHED_CNT_EN, when defined, SHALL add two output ports:
- cnt_a (8 bit): number of clock cycles spent in OWN_A.
- cnt_b (8 bit): number of clock cycles spent in OWN_B.
- Both counters wrap 255 -> 0 and reset to 0.
REQ-030 With GEN_SEL_SCHED_CNT_EN undefined, cnt_a and cnt_b and their logic SHALL be absent; all other behaviour is identical.

Verification
REQ-031 Reset, then req_a=1 only, a=4'hA, b=4'h5:
- gnt_a=1 and sel=1 at cycle 1.
- y=4'hA, z=4'h5, out_valid=1 at cycle 2.
REQ-032 HOLD=2, req_a=req_b=1 held for 8 cycles, starting from reset: grant pattern is A,A,B,B,A,A,B,B.
REQ-033 req_b only, a=4'h3, b=4'hC: sel=0, then y=4'hC, z=4'h3.
REQ-034 Early release: with HOLD=4, drop req_a one cycle into OWN_A with req_b high; OWN_B follows on the next edge.
REQ-035 Assert rst_n=0 mid-grant between edges: all outputs go to 0 before the next edge; the first tie after reset grants A.
REQ-036 With GEN_SEL_SCHED_CNT_EN defined, keep req_a high for 300 cycles: cnt_a wraps and reads 300 mod 256 = 44 ± the pipeline offset, checked against a reference model.
